btn_event_counter: RTL and testbench

- Parametrised successor to the single-button press counter used on the board top level.
- Debounces N_BTN raw push-buttons and produces a clean level and a one-cycle press pulse per channel.
- Drives a CNT_W-bit counter with increment, decrement, clear and load commands, plus a wrap flag.
- Sits between the board buttons and Led/7-seg display logic.
- Runs on the system clock; the button is not used as a clock.

---
 rtl/btn_event_counter.sv | 130 +++++++++++++
 tb/tb_btn_event_counter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/btn_event_counter.sv
// Debounced N_BTN button front end driving an up/down/clear/load counter; HOLD_REPEAT_EN adds INC/DEC auto-repeat.
// Latency: btn_level/btn_press 2+DB_CYCLES clk after a clean input edge, count/wrap one clk after a press.
// Backpressure: none, every command is applied in the cycle after it appears.
module btn_event_counter #(
  parameter int N_BTN         = 5,
  parameter int DB_CYCLES     = 1000000,
  parameter int CNT_W         = 8,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [CNT_W-1:0] load_val,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam int DB_W = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [N_BTN-1:0] sync_q1;
  logic [N_BTN-1:0] sync_q2;
  logic [DB_W-1:0]  db_cnt [N_BTN];
  logic             inc_cmd;
  logic             dec_cmd;
  logic             clr_cmd;
  logic             load_cmd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn_in;
      sync_q2 <= sync_q1;
    end
  end

  // Press pulse is raised on the same edge the level rises, so both read 1 together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_level <= '0;
      btn_press <= '0;
      for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
    end else begin
      btn_press <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        if (sync_q2[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_level[i] <= sync_q2[i];
          btn_press[i] <= sync_q2[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

`ifdef HOLD_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] hold_tmr [2];
  logic [1:0]       rpt_phase;
  logic [1:0]       rpt;

  // Phase 0 waits for the initial delay, phase 1 counts out each repeat period.
  always_comb begin
    rpt = '0;
    for (int i = 0; i < 2; i++) begin
      rpt[i] = btn_level[i] &&
               (hold_tmr[i] == (rpt_phase[i] ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_phase <= '0;
      for (int i = 0; i < 2; i++) hold_tmr[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!btn_level[i]) begin
          hold_tmr[i]  <= '0;
          rpt_phase[i] <= 1'b0;
        end else if (rpt[i]) begin
          hold_tmr[i]  <= RPT_W'(1);
          rpt_phase[i] <= 1'b1;
        end else begin
          hold_tmr[i] <= hold_tmr[i] + RPT_W'(1);
        end
      end
    end
  end

  assign inc_cmd = btn_press[0] | rpt[0];
  assign dec_cmd = btn_press[1] | rpt[1];
`else
  assign inc_cmd = btn_press[0];
  assign dec_cmd = btn_press[1];
`endif

  assign clr_cmd  = btn_press[2];
  assign load_cmd = btn_press[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr_cmd) begin
        count <= '0;
      end else if (load_cmd) begin
        count <= load_val;
      end else if (inc_cmd && !dec_cmd) begin
        count <= count + CNT_W'(1);
        wrap  <= (count == '1);
      end else if (dec_cmd && !inc_cmd) begin
        count <= count - CNT_W'(1);
        wrap  <= (count == '0);
      end
    end
  end

endmodule

// File: tb/tb_btn_event_counter.sv
// Directed bench for btn_event_counter with DB_CYCLES=4; the hold-repeat section follows HOLD_REPEAT_EN.
module tb_btn_event_counter;

  localparam int N_BTN = 5;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_BTN-1:0] btn_in;
  logic [CNT_W-1:0] load_val;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [CNT_W-1:0] count;
  logic             wrap;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int press_cnt0 = 0;
  int snap;

  btn_event_counter #(
    .N_BTN(N_BTN), .DB_CYCLES(4), .CNT_W(CNT_W), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .load_val(load_val),
    .btn_level(btn_level), .btn_press(btn_press), .count(count), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Number of cycles in which btn_press[0] was high.
  always @(posedge clk) press_cnt0 <= press_cnt0 + int'(btn_press[0]);

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Clean press of the channels in mask; returns one edge after the pulse, when count has updated.
  task automatic press(input logic [N_BTN-1:0] mask, input string tag);
    btn_in = mask;
    tick(6);
    chk({tag, "_pulse"}, 32'(btn_press), 32'(mask));
    btn_in = '0;
    tick(1);
  endtask

  initial begin
    rst      = 1'b1;
    btn_in   = 5'b10111;
    load_val = 8'hA5;
    #2;
    chk("rst_async_count", 32'(count), 32'h0);
    tick(3);
    btn_in = 5'b01010;
    tick(2);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_level", 32'(btn_level), 32'h0);
    chk("rst_press", 32'(btn_press), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    btn_in = '0;
    rst    = 1'b0;
    tick(1);
    chk("post_rst_all", {count, 3'b0, btn_level, 3'b0, btn_press, 7'b0, wrap}, 32'h0);
    tick(8);
    chk("idle_all", {count, 3'b0, btn_level, 3'b0, btn_press, 7'b0, wrap}, 32'h0);

    // Bounce: 2-cycle glitches must never pass a 4-cycle debounce.
    snap = press_cnt0;
    for (int k = 0; k < 5; k++) begin
      btn_in[0] = 1'b1;
      tick(2);
      btn_in[0] = 1'b0;
      tick(2);
    end
    chk("bounce_level_low", 32'(btn_level[0]), 32'h0);
    chk("bounce_no_pulse", 32'(press_cnt0 - snap), 32'h0);
    btn_in[0] = 1'b1;
    tick(5);
    chk("bounce_level_at5", 32'(btn_level[0]), 32'h0);
    chk("bounce_press_at5", 32'(btn_press[0]), 32'h0);
    tick(1);
    chk("bounce_level_at6", 32'(btn_level[0]), 32'h1);
    chk("bounce_press_at6", 32'(btn_press[0]), 32'h1);
    chk("bounce_count_at6", 32'(count), 32'h0);
    tick(1);
    chk("bounce_press_at7", 32'(btn_press[0]), 32'h0);
    chk("bounce_count_at7", 32'(count), 32'h1);
    btn_in[0] = 1'b0;
    tick(8);
    chk("bounce_level_fall", 32'(btn_level[0]), 32'h0);
    chk("bounce_one_pulse", 32'(press_cnt0 - snap), 32'h1);

    // Wrap in both directions.
    load_val = 8'hFF;
    press(5'b01000, "load_ff");
    chk("load_ff_count", 32'(count), 32'hFF);
    chk("load_ff_wrap", 32'(wrap), 32'h0);
    tick(8);
    press(5'b00001, "inc_wrap");
    chk("inc_wrap_count", 32'(count), 32'h00);
    chk("inc_wrap_flag", 32'(wrap), 32'h1);
    tick(1);
    chk("inc_wrap_single", 32'(wrap), 32'h0);
    tick(7);
    press(5'b00010, "dec_wrap");
    chk("dec_wrap_count", 32'(count), 32'hFF);
    chk("dec_wrap_flag", 32'(wrap), 32'h1);
    tick(1);
    chk("dec_wrap_single", 32'(wrap), 32'h0);
    tick(7);

    // Simultaneous commands and priority.
    load_val = 8'h05;
    press(5'b01000, "load_5");
    chk("load_5_count", 32'(count), 32'h05);
    tick(8);
    press(5'b00011, "inc_dec");
    chk("inc_dec_count", 32'(count), 32'h05);
    chk("inc_dec_wrap", 32'(wrap), 32'h0);
    tick(8);
    load_val = 8'h42;
    press(5'b01001, "load_inc");
    chk("load_over_inc", 32'(count), 32'h42);
    tick(8);
    press(5'b10000, "ch4");
    chk("ch4_no_cmd", 32'(count), 32'h42);
    tick(8);
    load_val = 8'h09;
    press(5'b01101, "clr_load_inc");
    chk("clr_wins", 32'(count), 32'h00);
    chk("clr_no_wrap", 32'(wrap), 32'h0);
    tick(8);

    // Reset while channel 0 is two cycles into its debounce.
    load_val = 8'h33;
    press(5'b01000, "pre_rst_load");
    tick(8);
    btn_in[0] = 1'b1;
    tick(4);
    rst = 1'b1;
    #1;
    chk("midrst_count", 32'(count), 32'h0);
    tick(1);
    snap = press_cnt0;
    rst  = 1'b0;
    tick(5);
    chk("midrst_no_early", 32'(press_cnt0 - snap), 32'h0);
    chk("midrst_level_at5", 32'(btn_level[0]), 32'h0);
    tick(1);
    chk("midrst_press_at6", 32'(btn_press[0]), 32'h1);
    tick(1);
    chk("midrst_count_at7", 32'(count), 32'h1);
    tick(5);
    chk("midrst_one_pulse", 32'(press_cnt0 - snap), 32'h1);
    btn_in[0] = 1'b0;
    tick(8);

    // Long hold of INC from count 0: level stays high 27 cycles.
    press(5'b00100, "pre_hold_clr");
    tick(8);
    snap = press_cnt0;
    btn_in[0] = 1'b1;
    tick(16);
    chk("hold_count_c9", 32'(count), 32'h1);
`ifdef HOLD_REPEAT_EN
    tick(1);
    chk("hold_count_c10", 32'(count), 32'h2);
    tick(10);
    btn_in[0] = 1'b0;
    tick(6);
    chk("hold_level_fall", 32'(btn_level[0]), 32'h0);
    chk("hold_count_end", 32'(count), 32'h5);
`else
    tick(11);
    btn_in[0] = 1'b0;
    tick(6);
    chk("hold_level_fall", 32'(btn_level[0]), 32'h0);
    chk("hold_count_end", 32'(count), 32'h1);
`endif
    tick(4);
    chk("hold_count_settled", 32'(count - (count - 8'(press_cnt0 - snap))), 32'(press_cnt0 - snap));
    chk("hold_one_pulse", 32'(press_cnt0 - snap), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
